// File: rtl/ram_port_ctrl_if.sv
// ram_port_ctrl_if
//   Request/response bundle for one port of the dual-port RAM bus.
//   Parameters: ADDR_WIDTH (request address width), BUS_WIDTH (data width).
//   Signals:
//     en, addr, addr_valid, addr_ready, we   address channel and port enable
//     data_in, valid_w, ready_w              write data channel
//     data_out, valid_r, ready_r             read response channel
//   Modports:
//     master  requester side (drives requests, consumes responses)
//     slave   controller side (ram_port_ctrl)
interface ram_port_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 64
);
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_valid;
    logic                  addr_ready;
    logic                  we;
    logic [BUS_WIDTH-1:0]  data_in;
    logic                  valid_w;
    logic                  ready_w;
    logic [BUS_WIDTH-1:0]  data_out;
    logic                  valid_r;
    logic                  ready_r;

    modport master (
        output en, addr, addr_valid, we, data_in, valid_w, ready_r,
        input  addr_ready, ready_w, data_out, valid_r
    );

    modport slave (
        input  en, addr, addr_valid, we, data_in, valid_w, ready_r,
        output addr_ready, ready_w, data_out, valid_r
    );
endinterface

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl
//   Per-port handshake engine for the dual-port RAM. Turns one address/write/read
//   valid-ready transaction into a single-cycle access on one port of the raw
//   synchronous array, flags out-of-range addresses and buffers the read response
//   until the consumer takes it. One transaction is outstanding at a time.
//   Ports:
//     aclk, aresetn   clock (rising edge) and asynchronous active-low reset
//     bus             ram_port_ctrl_if.slave request/response channels
//     mem_en, mem_we  array port enable / write enable
//     mem_addr        array word address
//     mem_wdata       array write data
//     mem_rdata       array read data, valid the cycle after a read enable
//     oor_cnt         saturating count of out-of-range transactions
//     busy            high whenever a transaction is in flight
module ram_port_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    ram_port_ctrl_if.slave                bus,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
    output logic [BUS_WIDTH-1:0]          mem_wdata,
    input  logic [BUS_WIDTH-1:0]          mem_rdata,
    output logic [15:0]                   oor_cnt,
    output logic                          busy
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WR    = 3'd2,
        RD    = 3'd3,
        RCAP  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rst_done;
    logic [MEM_AW-1:0]    addr_q;
    logic                 we_q;
    logic                 oor_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic [15:0]          oor_cnt_q;

    logic                 addr_ready_c;
    logic                 ready_w_c;
    logic                 valid_r_c;
    logic                 addr_hs;
    logic                 wdata_hs;
    logic                 addr_oor;

    assign addr_hs  = addr_ready_c && bus.addr_valid;
    assign wdata_hs = ready_w_c && bus.valid_w;
    assign addr_oor = {1'b0, bus.addr} >= DEPTH_LIMIT;

    // State register. rst_done keeps addr_ready low until the first edge after
    // reset release, so every output reads 0 while reset is held.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_next;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (addr_hs) state_next = bus.we ? WDATA : RD;
            WDATA:   if (wdata_hs) state_next = WR;
            WR:      state_next = IDLE;
            RD:      state_next = RCAP;
            RCAP:    state_next = RESP;
            RESP:    if (bus.ready_r) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Array strobes come straight from the registered state so they cannot glitch.
    always_comb begin
        addr_ready_c = 1'b0;
        ready_w_c    = 1'b0;
        valid_r_c    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        case (state)
            IDLE:    addr_ready_c = bus.en && rst_done;
            WDATA:   ready_w_c    = 1'b1;
            WR: begin
                mem_en = !oor_q;
                mem_we = !oor_q && we_q;
            end
            RD:      mem_en       = !oor_q;
            RESP:    valid_r_c    = 1'b1;
            default: ;
        endcase
    end

    // Transaction latches, read capture and the saturating out-of-range counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            oor_cnt_q <= '0;
        end else begin
            if (addr_hs) begin
                addr_q <= bus.addr[MEM_AW-1:0];
                we_q   <= bus.we;
                oor_q  <= addr_oor;
            end
            if (wdata_hs) begin
                wdata_q <= bus.data_in;
            end
            if (state == RCAP) begin
                rdata_q <= oor_q ? '0 : mem_rdata;
            end
            if ((state == WR || state == RD) && oor_q && oor_cnt_q != 16'hFFFF) begin
                oor_cnt_q <= oor_cnt_q + 16'd1;
            end
        end
    end

    assign bus.addr_ready = addr_ready_c;
    assign bus.ready_w    = ready_w_c;
    assign bus.valid_r    = valid_r_c;
    assign bus.data_out   = rdata_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign oor_cnt        = oor_cnt_q;
    assign busy           = (state != IDLE);

endmodule
